fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core: owns the program counter, drives the combinational instruction memory's byte address, and captures the returned word into the IF/ID pipeline register. It sits directly upstream of decode, applies stall, flush and branch redirects from the hazard unit and EX stage, and flags misaligned or out-of-range fetches.

---
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the RV32I pipeline. It owns the PC, addresses the combinational
// instruction memory and registers the fetched word into IF/ID. It also handles stall, flush and redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_SIZE = 128
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemData,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic [31:0] PC_ID,
  output logic [31:0] PCPlus4_ID,
  output logic [31:0] Instr_ID,
  output logic        Valid_ID,
  output logic [31:0] FetchCount,
  output logic        MisalignErr,
  output logic        RangeErr
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_SIZE - 4);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] pcp4_id_q, pcp4_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;
  logic        range_q, range_d;

  logic [31:0] pc_plus4;
  logic        do_bubble;
  logic        do_load;

  // Valid_ID qualifies the IF/ID contents: when low, the register holds a NOP bubble and
  // downstream must not treat it as a fetched instruction. There is no backpressure beyond Stall.
  always_comb begin
    pc_plus4      = pc_q + 32'd4;
    do_bubble     = 1'b0;
    do_load       = 1'b0;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q;
    range_d       = range_q;

    if (BranchTaken) begin
      pc_d      = {BranchTarget[31:2], 2'b00};
      do_bubble = 1'b1;
      if (BranchTarget[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (Stall) begin
      do_bubble = Flush;
    end else if (Flush) begin
      pc_d      = pc_plus4;
      do_bubble = 1'b1;
    end else begin
      pc_d = pc_plus4;
      // Out-of-range fetches are dropped, but the PC keeps walking.
      if (pc_q > LAST_ADDR) begin
        do_bubble = 1'b1;
        range_d   = 1'b1;
      end else begin
        do_load       = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end

    pc_id_d    = pc_id_q;
    pcp4_id_d  = pcp4_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    if (do_bubble) begin
      pc_id_d    = 32'd0;
      pcp4_id_d  = 32'd0;
      instr_id_d = NOP;
      valid_id_d = 1'b0;
    end else if (do_load) begin
      pc_id_d    = pc_q;
      pcp4_id_d  = pc_plus4;
      instr_id_d = IMemData;
      valid_id_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q          <= RESET_PC;
      pc_id_q       <= 32'd0;
      pcp4_id_q     <= 32'd0;
      instr_id_q    <= NOP;
      valid_id_q    <= 1'b0;
      fetch_count_q <= 32'd0;
      misalign_q    <= 1'b0;
      range_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pc_id_q       <= pc_id_d;
      pcp4_id_q     <= pcp4_id_d;
      instr_id_q    <= instr_id_d;
      valid_id_q    <= valid_id_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
      range_q       <= range_d;
    end
  end

  assign IMemAddress = pc_q;
  assign PC_ID       = pc_id_q;
  assign PCPlus4_ID  = pcp4_id_q;
  assign Instr_ID    = instr_id_q;
  assign Valid_ID    = valid_id_q;
  assign FetchCount  = fetch_count_q;
  assign MisalignErr = misalign_q;
  assign RangeErr    = range_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural model predicts the visible state after every edge.
// A monitor pops those predictions one edge later and compares them with the outputs.
module tb_fetch_stage;

  localparam int W = 163;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc_id;
    logic [31:0] pcp4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
    logic        rng;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr, imem_data;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_id, pcp4_id, instr_id, fetch_count;
  logic        valid_id, misalign_err, range_err;

  logic [31:0] mem [32];
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: the PC and what IF/ID should hold.
  logic [31:0] m_pc, m_pc_id, m_pcp4, m_instr, m_cnt;
  logic        m_valid, m_mis, m_rng;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_SIZE(128)) dut (
    .CLK(clk), .RESET(rst_n),
    .IMemAddress(imem_addr), .IMemData(imem_data),
    .Stall(stall), .Flush(flush), .BranchTaken(branch_taken), .BranchTarget(branch_target),
    .PC_ID(pc_id), .PCPlus4_ID(pcp4_id), .Instr_ID(instr_id), .Valid_ID(valid_id),
    .FetchCount(fetch_count), .MisalignErr(misalign_err), .RangeErr(range_err)
  );

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (a < 32'd128) return mem[a[6:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_data = fetch_word(imem_addr);

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: one prediction per edge, compared shortly after that edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t e;
      e = obs_t'(exp_q.pop_front());
      chk("sb_addr",  imem_addr,    e.addr);
      chk("sb_pc_id", pc_id,        e.pc_id);
      chk("sb_pcp4",  pcp4_id,      e.pcp4);
      chk("sb_instr", instr_id,     e.instr);
      chk("sb_valid", 32'(valid_id), 32'(e.valid));
      chk("sb_cnt",   fetch_count,  e.cnt);
      chk("sb_mis",   32'(misalign_err), 32'(e.mis));
      chk("sb_rng",   32'(range_err), 32'(e.rng));
    end
  end

  task automatic model_bubble();
    m_pc_id = 0; m_pcp4 = 0; m_instr = NOP; m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_mis = 0; m_rng = 0;
    model_bubble();
  endtask

  // Drive inputs for the coming edge and push the predicted post-edge view.
  task automatic apply(input logic st, input logic fl, input logic bt, input logic [31:0] tgt);
    obs_t e;
    stall = st; flush = fl; branch_taken = bt; branch_target = tgt;
    if (bt) begin
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc = tgt - (tgt % 4);
      model_bubble();
    end else if (st) begin
      if (fl) model_bubble();
    end else if (fl) begin
      m_pc = m_pc + 4;
      model_bubble();
    end else begin
      if (m_pc > 124) begin
        model_bubble();
        m_rng = 1'b1;
      end else begin
        m_pc_id = m_pc; m_pcp4 = m_pc + 4; m_instr = fetch_word(m_pc); m_valid = 1'b1;
        m_cnt = m_cnt + 1;
      end
      m_pc = m_pc + 4;
    end
    e = '{addr: m_pc, pc_id: m_pc_id, pcp4: m_pcp4, instr: m_instr, valid: m_valid,
          cnt: m_cnt, mis: m_mis, rng: m_rng};
    exp_q.push_back(W'(e));
  endtask

  task automatic step(input logic st, input logic fl, input logic bt, input logic [31:0] tgt);
    @(posedge clk); #3;
    apply(st, fl, bt, tgt);
  endtask

  // Reset between edges, check it took effect at once, then release with a free fetch queued.
  task automatic do_reset();
    @(posedge clk); #5;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(valid_id), 32'h0);
    chk("rst_instr", instr_id, NOP);
    chk("rst_cnt",   fetch_count, 32'h0);
    chk("rst_mis",   32'(misalign_err), 32'h0);
    chk("rst_rng",   32'(range_err), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    apply(0, 0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0093;
    mem[1] = 32'h0010_0113;
    mem[2] = 32'h0370_0293;
    mem[3] = 32'h0020_81B3;
    model_reset();
    repeat (2) @(posedge clk);

    // Sequential fetch of the first three words.
    do_reset();
    step(0, 0, 0, 0);
    chk("seq1_instr", instr_id, 32'h0000_0093);
    chk("seq1_pc",    pc_id, 32'h0);
    step(0, 0, 0, 0);
    chk("seq2_instr", instr_id, 32'h0010_0113);
    chk("seq2_pc",    pc_id, 32'h4);
    step(0, 0, 0, 0);
    chk("seq3_instr", instr_id, 32'h0370_0293);
    chk("seq3_pc",    pc_id, 32'h8);
    chk("seq3_valid", 32'(valid_id), 32'h1);
    chk("seq3_cnt",   fetch_count, 32'd3);
    repeat (2) step(0, 0, 0, 0);

    // Stall at PC 8, then redirect under stall, then a misaligned redirect.
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("stall1_addr",  imem_addr, 32'h8);
    chk("stall1_instr", instr_id, 32'h0010_0113);
    chk("stall1_cnt",   fetch_count, 32'd2);
    step(0, 0, 0, 0);
    chk("stall2_addr",  imem_addr, 32'h8);
    chk("stall2_instr", instr_id, 32'h0010_0113);
    step(1, 0, 1, 32'h0C);
    chk("post_stall_instr", instr_id, 32'h0370_0293);
    step(0, 0, 0, 0);
    chk("br_valid", 32'(valid_id), 32'h0);
    chk("br_addr",  imem_addr, 32'h0C);
    step(0, 0, 1, 32'h0E);
    chk("br_tgt_instr", instr_id, 32'h0020_81B3);
    chk("br_tgt_pc",    pc_id, 32'h0C);
    step(0, 0, 1, 32'h40);
    chk("mis_addr", imem_addr, 32'h0C);
    chk("mis_flag", 32'(misalign_err), 32'h1);
    step(0, 0, 0, 0);
    chk("mis_sticky", 32'(misalign_err), 32'h1);

    // Randomised mix of stall, flush and redirect.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic st, fl, bt;
      logic [31:0] tgt;
      r  = $urandom_range(0, 99);
      st = (r < 20);
      fl = (r >= 15 && r < 30);
      bt = ($urandom_range(0, 99) < 8);
      tgt = (($urandom_range(0, 99) < 80) ? $urandom_range(0, 39) * 4 : $urandom_range(0, 160));
      step(st, fl, bt, tgt);
    end

    // Run off the end of a 128-byte memory.
    do_reset();
    step(0, 0, 1, 32'h70);
    step(0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rng_valid", 32'(valid_id), 32'h0);
    chk("rng_instr", instr_id, NOP);
    chk("rng_flag",  32'(range_err), 32'h1);
    chk("rng_cnt",   fetch_count, 32'd5);
    chk("rng_addr",  imem_addr, 32'h84);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_rng", 32'(range_err), 32'h1);

    @(posedge clk); #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
